// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU, one operation in flight.
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational, operands latched on accept
//   EXEC  | shared ALU evaluates latched operands; result registered at end of cycle
//   HOLD  | result presented on res_*; waits for res_ready, then back to IDLE
//
// Ports
//   clk                  sole clock, rising edge
//   rst                  synchronous active-low reset
//   req0_valid/req1_valid  requester presents an operation
//   req0_ready/req1_ready  operation accepted this cycle (combinational)
//   req0_a/_b, req1_a/_b   signed operands, WIDTH bits
//   req0_ctrl/req1_ctrl    000 AND, 001 OR, 010 ADD, 110 SUB, else signed set-less-than
//   res_valid/res_ready    result handshake
//   res_y, res_zero, res_id  result value, zero flag, owning requester
//   op_count             number of results consumed, wraps at 16 bits
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_ctrl,
    input  logic [2:0]       req1_ctrl,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_zero,
    output logic             res_id,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic             id_q;
    logic             last_gnt;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] alu_y;

    // last_gnt = 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_y = '0;
        case (ctrl_q)
            3'b000:  alu_y = a_q & b_q;
            3'b001:  alu_y = a_q | b_q;
            3'b010:  alu_y = a_q + b_q;
            3'b110:  alu_y = a_q - b_q;
            default: alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            id_q      <= 1'b0;
            last_gnt  <= 1'b1;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_zero  <= 1'b0;
            res_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q    <= gnt1 ? req1_a    : req0_a;
                        b_q    <= gnt1 ? req1_b    : req0_b;
                        ctrl_q <= gnt1 ? req1_ctrl : req0_ctrl;
                        id_q   <= gnt1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_y     <= alu_y;
                    res_zero  <= (alu_y == '0);
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        last_gnt  <= res_id;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: scoreboard of expected results pushed at grant
// time and popped when the DUT completes a res_valid/res_ready handshake.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        res_valid, res_ready;
    logic [31:0] res_y;
    logic        res_zero, res_id;
    logic [15:0] op_count;

    typedef struct {
        logic [31:0] y;
        logic        id;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_cnt;
    logic        m_last;
    int          n_tests;
    int          n_fail;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ctrl  (req0_ctrl),
        .req1_ctrl  (req1_ctrl),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_zero   (res_zero),
        .res_id     (res_id),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Result checker: compares every consumed result against the scoreboard.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_y", res_y, mon_e.y);
                chk("res_zero", {31'd0, res_zero}, {31'd0, (mon_e.y == 32'd0)});
                chk("res_id", {31'd0, res_id}, {31'd0, mon_e.id});
                chk("pre_cnt", {16'd0, op_count}, {16'd0, exp_cnt});
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in EXEC.
    task automatic issue(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1);
        logic g0, g1;
        exp_t e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        #1;
        g1 = v1 && (!v0 || (m_last == 1'b0));
        g0 = v0 && !g1;
        chk("rdy0", {31'd0, req0_ready}, {31'd0, g0});
        chk("rdy1", {31'd0, req1_ready}, {31'd0, g1});
        e.y  = g1 ? model(a1, b1, c1) : model(a0, b0, c0);
        e.id = g1;
        exp_q.push_back(e);
        m_last = g1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic run_op(input logic v0, input logic v1,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                          input int stall, input bit scramble);
        logic [31:0] y0;
        issue(v0, v1, a0, b0, c0, a1, b1, c1);
        if (scramble) begin
            req0_a = ~req0_a; req0_b = req0_b + 32'd17; req0_ctrl = 3'b001;
            req1_a = ~req1_a; req1_ctrl = 3'b000;
        end
        chk("lat_exec", {31'd0, res_valid}, 32'd0);
        res_ready = (stall == 0);
        @(posedge clk); #1;
        chk("lat_hold", {31'd0, res_valid}, 32'd1);
        if (stall > 0) begin
            y0 = exp_q[0].y;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                chk("bp_valid", {31'd0, res_valid}, 32'd1);
                chk("bp_y", res_y, y0);
                chk("bp_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
                chk("bp_cnt", {16'd0, op_count}, {16'd0, exp_cnt});
                @(posedge clk); #1;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            res_ready  = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_valid", {31'd0, res_valid}, 32'd0);
        chk("cnt", {16'd0, op_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        v0, v1;
        logic [2:0]  c0, c1;
        logic [31:0] a0, b0, a1, b1;
        n_tests = 0; n_fail = 0; exp_cnt = 16'd0; m_last = 1'b1;
        rst = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_ctrl = '0; req1_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_y", res_y, 32'd0);
        chk("rst_zero", {31'd0, res_zero}, 32'd0);
        chk("rst_id", {31'd0, res_id}, 32'd0);
        chk("rst_cnt", {16'd0, op_count}, 32'd0);
        chk("rst_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // single ADD
        run_op(1, 0, 32'd5, 32'd3, 3'b010, 0, 0, 0, 0, 0);
        chk("single_cnt", {16'd0, op_count}, 32'd1);

        // ties: req0 then req1, then alternate
        run_op(1, 1, 32'd7, 32'd7, 3'b110, 32'h0F, 32'hF0, 3'b001, 0, 0);
        run_op(0, 1, 0, 0, 0, 32'h0F, 32'hF0, 3'b001, 0, 0);
        run_op(1, 1, 32'd1, 32'd2, 3'b000, 32'd9, 32'd4, 3'b110, 0, 0);
        run_op(1, 1, 32'd1, 32'd2, 3'b001, 32'd9, 32'd4, 3'b110, 0, 0);

        // backpressure
        run_op(0, 1, 0, 0, 0, 32'd100, 32'd23, 3'b010, 5, 0);

        // SLT and wrap
        run_op(1, 0, 32'hFFFF_FFFF, 32'd1, 3'b111, 0, 0, 0, 0, 0);
        run_op(1, 0, 32'h7FFF_FFFF, 32'd1, 3'b010, 0, 0, 0, 0, 0);
        run_op(1, 0, 32'd1, 32'hFFFF_FFFF, 3'b111, 0, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 0, 32'd0, 32'd1, 3'b110, 0, 0);

        // operands changed after accept
        run_op(1, 0, 32'h1234_5678, 32'h0000_1111, 3'b010, 0, 0, 0, 1, 1);

        // reset during EXEC
        issue(1, 0, 32'd40, 32'd2, 3'b010, 0, 0, 0);
        rst = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("rst_rdy_exec", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mid_cnt", {16'd0, op_count}, 32'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        m_last = 1'b1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1, 0, 0, 0, 32'd6, 32'd9, 3'b010, 0, 0);
        run_op(1, 1, 32'd3, 32'd3, 3'b110, 32'd1, 32'd1, 3'b001, 0, 0);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom(); b0 = (k % 4 == 0) ? a0 : $urandom();
            a1 = $urandom(); b1 = $urandom();
            c0 = 3'($urandom_range(0, 7));
            c1 = 3'($urandom_range(0, 7));
            run_op(v0, v1, a0, b0, c0, a1, b1, c1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  signed operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl  input  3  op: 000 AND, 001 OR, 010 ADD, 110 SUB, any other signed set-less-than.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer takes result.
REQ-010 SHALL have port res_y  output  WIDTH  result value.
REQ-011 SHALL have port res_zero  output  1  high when res_y is zero.
REQ-012 SHALL have port res_id  output  1  requester index owning the result.
REQ-013 SHALL have port op_count  output  16  count of results consumed.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, HOLD; one shared ALU, one operation in flight.
REQ-015 In IDLE with any reqN_valid high, SHALL assert exactly one reqN_ready (combinational, same cycle) and latch that requester's a, b, ctrl and index; next state EXEC.
REQ-016 Only one valid high: SHALL grant it regardless of priority.
REQ-017 Both valid high: SHALL grant the requester not granted last (round-robin); after reset requester 0 wins first tie.
REQ-018 reqN_ready SHALL be low in EXEC and HOLD and whenever reqN_valid is low.
REQ-019 In EXEC SHALL compute on latched operands and register res_y, res_zero, res_id; next state HOLD.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH, no overflow flag; SLT SHALL compare signed and produce 1 or 0 zero-extended to WIDTH.
REQ-021 res_zero SHALL equal (res_y == 0) for every op, including SLT false result.
REQ-022 res_valid SHALL be high exactly in HOLD; res_y, res_zero, res_id SHALL hold stable while res_valid high.
REQ-023 In HOLD with res_ready high SHALL return to IDLE, update last-granted to res_id, increment op_count; with res_ready low SHALL stay in HOLD indefinitely.
REQ-024 Latency: accept edge at cycle N -> res_valid high from cycle N+2; minimum spacing between accepts 3 cycles.
REQ-025 op_count SHALL wrap from 16'hFFFF to 0.
REQ-026 Requester inputs SHALL be ignored outside the IDLE accept cycle; changing them after accept SHALL not alter the result.
REQ-027 res_ready high outside HOLD SHALL have no effect.

Reset
REQ-028 rst low at a rising edge SHALL force IDLE, res_valid 0, res_y 0, res_zero 0, res_id 0, op_count 0, last-granted = 1 (so requester 0 wins first tie).
REQ-029 While rst low both reqN_ready SHALL be 0.
REQ-030 Reset asserted in EXEC or HOLD SHALL discard the in-flight operation; no result emitted, op_count not incremented.

Verification
REQ-031 Single op: req0 a=5 b=3 ctrl=010, res_ready=1 -> req0_ready in accept cycle, res_valid two cycles later, res_y=8, res_zero=0, res_id=0, op_count=1.
REQ-032 Tie: both valid after reset, req0 SUB 7-7, req1 OR 0x0F|0xF0 -> req0 first (res_y=0, res_zero=1), then req1 (res_y=0xFF, res_id=1); next tie grants req0.
REQ-033 Backpressure: res_ready low 5 cycles in HOLD -> res_valid and res_y stable, both reqN_ready 0, op_count unchanged until res_ready high.
REQ-034 SLT/wrap: a=-1 b=1 ctrl=111 -> res_y=1; a=0x7FFFFFFF b=1 ctrl=010 -> res_y=0x80000000; a=1 b=-1 ctrl=111 -> res_y=0, res_zero=1.
REQ-035 Reset mid-op: rst low during EXEC -> next cycle res_valid 0, op_count 0, IDLE; a fresh req1 then accepted normally.
REQ-036 Operand change after accept: req0_a altered in EXEC -> result reflects originally latched operands.
